// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB-first, one bit per clock through a single full adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fa_sum, fa_carry;
  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .c(carry_q), .sum(fa_sum), .carry(fa_carry));
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (state_q == RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      carry_d = fa_carry;
      cnt_d   = cnt_q + CNT_W'(1);
      res_d   = WIDTH'({fa_sum, res_q} >> 1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d   = res_d;
        cout_d  = fa_carry;
      end
    end else if (start) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      cnt_d   = '0;
      res_d   = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder against an arithmetic model
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0, cin = 1'b0, busy, done, cout;
  logic [7:0] a = '0, b = '0, sum;
  logic start3 = 1'b0, cin3 = 1'b0, busy3, done3, cout3;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );
  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
  );

  function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic c,
                       output int busy_cycles, output logic [7:0] s, output logic co, output logic ok);
    int n;
    a = x; b = y; cin = c; start = 1'b1;
    step();
    start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (!done && n < 40) begin
      if (busy) busy_cycles++;
      step();
      n++;
    end
    ok = done;
    s = sum;
    co = cout;
  endtask

  task automatic test_reset();
    checks++; if ({busy, done, cout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got busy=%b done=%b cout=%b expected 0 0 0", busy, done, cout); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h expected 00", sum); end
    checks++; if ({busy3, done3, cout3, sum3} !== 6'b0) begin errors++; $display("FAIL reset_w3: got %b expected 0", {busy3, done3, cout3, sum3}); end
  endtask

  task automatic test_basic();
    int bc; logic [7:0] s; logic co, ok;
    do_op(8'h0F, 8'h01, 1'b0, bc, s, co, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", ok); end
    checks++; if (bc != 8) begin errors++; $display("FAIL basic_busy_len: got %0d expected 8", bc); end
    checks++; if (s !== 8'h10) begin errors++; $display("FAIL basic_sum: got %h expected 10", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", co); end
  endtask

  task automatic test_carry();
    int bc; logic [7:0] s; logic co, ok;
    do_op(8'hFF, 8'h01, 1'b0, bc, s, co, ok);
    checks++; if ({ok, co, s} !== {1'b1, 1'b1, 8'h00}) begin errors++; $display("FAIL carry_ff01: got ok=%b cout=%b sum=%h expected 1 1 00", ok, co, s); end
    do_op(8'hFF, 8'hFF, 1'b1, bc, s, co, ok);
    checks++; if ({ok, co, s} !== {1'b1, 1'b1, 8'hFF}) begin errors++; $display("FAIL carry_ffff1: got ok=%b cout=%b sum=%h expected 1 1 ff", ok, co, s); end
  endtask

  task automatic test_ignore_start();
    int nd; logic [7:0] s; logic co;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0; a = '0; b = '0;
    nd = 0; s = 'x; co = 'x;
    for (int i = 0; i < 30; i++) begin
      if (done) begin nd++; s = sum; co = cout; end
      step();
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    checks++; if (s !== 8'h46) begin errors++; $display("FAIL ignore_sum: got %h expected 46", s); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL ignore_cout: got %b expected 0", co); end
  endtask

  task automatic test_reset_mid();
    int nd, bc; logic [7:0] s; logic co, ok; logic [8:0] exp;
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, cout} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got busy=%b done=%b cout=%b expected 0 0 0", busy, done, cout); end
    checks++; if (sum !== 8'h00) begin errors++; $display("FAIL midrst_sum: got %h expected 00", sum); end
    step();
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) nd++;
      step();
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL midrst_activity: got %0d active cycles expected 0", nd); end
    do_op(8'h3C, 8'hC3, 1'b1, bc, s, co, ok);
    exp = ref_add(8'h3C, 8'hC3, 1'b1);
    checks++; if ({ok, co, s} !== {1'b1, exp}) begin errors++; $display("FAIL midrst_recover: got ok=%b {cout,sum}=%h expected 1 %h", ok, {co, s}, exp); end
  endtask

  task automatic test_back_to_back();
    int last, nd, n;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    last = -1; nd = 0;
    for (int cyc = 0; cyc < 41; cyc++) begin
      step();
      checks++; if (busy && done) begin errors++; $display("FAIL b2b_overlap: got busy=1 done=1 at cycle %0d expected exclusive", cyc); end
      if (done) begin
        checks++; if (sum !== 8'h02) begin errors++; $display("FAIL b2b_sum: got %h expected 02", sum); end
        if (last >= 0) begin
          checks++; if (cyc - last != 9) begin errors++; $display("FAIL b2b_period: got %0d expected 9", cyc - last); end
        end
        last = cyc; nd++;
      end else if (nd > 0) begin
        checks++; if (sum !== 8'h02) begin errors++; $display("FAIL b2b_stable: got %h expected 02 at cycle %0d", sum, cyc); end
      end
    end
    start = 1'b0;
    checks++; if (nd != 4) begin errors++; $display("FAIL b2b_done_count: got %0d expected 4", nd); end
    n = 0;
    while ((busy || done) && n < 20) begin step(); n++; end
  endtask

  task automatic test_random();
    int bc; logic [7:0] s, x, y; logic co, ok, c; logic [8:0] exp;
    repeat (20) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      do_op(x, y, c, bc, s, co, ok);
      exp = ref_add(x, y, c);
      checks++; if ({ok, co, s} !== {1'b1, exp}) begin errors++; $display("FAIL random_add %h+%h+%b: got ok=%b {cout,sum}=%h expected 1 %h", x, y, c, ok, {co, s}, exp); end
    end
  endtask

  task automatic test_w3_sweep();
    int n, exp;
    for (int ai = 0; ai < 8; ai++)
      for (int bi = 0; bi < 8; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          a3 = 3'(ai); b3 = 3'(bi); cin3 = 1'(ci); start3 = 1'b1;
          step();
          start3 = 1'b0;
          n = 0;
          while (!done3 && n < 10) begin step(); n++; end
          exp = ai + bi + ci;
          checks++; if ({done3, cout3, sum3} !== {1'b1, 4'(exp)}) begin errors++; $display("FAIL w3_add %0d+%0d+%0d: got done=%b {cout,sum}=%0d expected 1 %0d", ai, bi, ci, done3, {cout3, sum3}, exp); end
        end
  endtask

  initial begin
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_carry();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_w3_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
